alu_result_collector: RTL and testbench
=======================================

# alu_result_collector

Downstream stage of ALU_TOP. Captures the flag-qualified result from whichever ALU unit fired, normalises it to one 32-bit word tagged with its function code and carry, and buffers it in a small first-word-fall-through FIFO with a valid/ready output handshake. Also keeps sticky error and drop statistics so software-facing logic can detect lost or malformed results.

## Interface
- DATA_WIDTH, 32, width of buffered result word (equals ALU_TOP ARITH_OUT_WIDTH)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CNT_WIDTH, 8, width of drop/error counters
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- ALU_FUN  in  4  same code driven into ALU_TOP this cycle
- Arith_OUT  in  32  ALU arithmetic result
- Carry_Out  in  1  ALU carry
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  in  1 each  ALU unit-valid flags
- logic_OUT  in  16  ALU logic result
- CMP_OUT  in  4  ALU compare result
- SHIFT_OUT  in  17  ALU shift result
- Res_Ready  in  1  consumer accepts head entry
- CLR_Stats  in  1  clears Err_Multi, Drop_Cnt, Err_Cnt
- Res_Valid  out  1  head entry valid
- Res_Data  out  DATA_WIDTH  head result
- Res_Fun  out  4  head function code
- Res_Carry  out  1  head carry
- Fill_Level  out  log2(DEPTH)+1  occupied entries
- Full  out  1  Fill_Level == DEPTH
- Err_Multi  out  1  sticky: more than one flag seen high
- Drop_Cnt  out  CNT_WIDTH  results lost to full FIFO, saturating
- Err_Cnt  out  CNT_WIDTH  multi-flag cycles, saturating

## Operation
- ALU_TOP outputs lag ALU_FUN by one cycle; block registers ALU_FUN into fun_d every cycle; fun_d is the tag for the flags seen this cycle.
- Flag decode per cycle (one-hot check on {Arith,Logic,CMP,Shift}):
  - none high: no push.
  - exactly one: push candidate. Arith → data=Arith_OUT, carry=Carry_Out. Logic → zero-extend logic_OUT, carry=0. CMP → zero-extend CMP_OUT, carry=0. Shift → zero-extend SHIFT_OUT (bit16 lands in Res_Data[16]), carry=0.
  - two or more: no push; Err_Multi←1; Err_Cnt increments (saturate at all-ones).
- Push acceptance: accepted if Fill_Level<DEPTH, or if FIFO full and pop occurs same cycle. Otherwise dropped; Drop_Cnt increments (saturate).
- Pop: Res_Valid && Res_Ready. Ready while empty is ignored.
- FIFO: circular write/read pointers, wrap modulo DEPTH; Fill_Level updates +1 push only, −1 pop only, unchanged on both.
- CLR_Stats clears stats at edge; if an error/drop event coincides, CLR_Stats wins (result 0, Err_Multi 0).
- Res_Data/Res_Fun/Res_Carry show head entry combinationally from storage; hold stale storage when Res_Valid=0 (don't-care, not checked).

## Timing
- All state updates on CLK rising edge; RST sampled only at edge.
- RST high: pointers, Fill_Level, fun_d, Err_Multi, Drop_Cnt, Err_Cnt ← 0; Res_Valid=0, Full=0; Res_Data/Res_Fun/Res_Carry ← 0 (storage cleared). Reset mid-stream discards all entries; RST overrides push, pop, CLR_Stats.
- ALU_FUN at cycle N-1, flag at cycle N → Res_Valid high from cycle N+1 (one-cycle latency flag→valid), Res_Fun = ALU_FUN of N-1.
- Pop at edge E: next entry (if any) visible immediately after E; back-to-back one pop per cycle sustainable.
- Full→push+pop same cycle: both succeed, Fill_Level stays DEPTH, Drop_Cnt unchanged.
- Empty→push with Res_Ready high: entry not popped that cycle (not yet valid); popped next cycle.

## Test plan
- Reset: RST=1 two cycles → Res_Valid=0, Fill_Level=0, Drop_Cnt=0, Err_Multi=0, Res_Data=0.
- Arith push: ALU_FUN=0, next cycle Arith_Flag=1, Arith_OUT=-10 (0xFFFFFFF6), Carry_Out=1 → next cycle Res_Valid=1, Res_Data=0xFFFFFFF6, Res_Fun=0, Res_Carry=1; Res_Ready=1 → Fill_Level 1→0.
- Normalisation: Logic 0xFFF0 fun 7, CMP 3 fun 11, Shift 17'h10014 fun 13 pushed consecutively, Res_Ready=0 → pops give 0x0000FFF0/7, 0x00000003/11, 0x00010014/13, all carry 0.
- Full/drop: 6 single-flag pushes, Res_Ready=0 → Fill_Level=4, Full=1, Drop_Cnt=2; then push with Res_Ready=1 → Fill_Level stays 4, Drop_Cnt=2, order preserved after pointer wrap.
- Multi-flag: Arith_Flag=Logic_Flag=1 one cycle → no push, Err_Multi=1, Err_Cnt=1; CLR_Stats=1 → both 0; 300 drops → Drop_Cnt saturates at 255.
- Reset mid-operation: 3 entries queued, RST=1 one cycle with a simultaneous push → Fill_Level=0, Res_Valid=0, pushed entry discarded.

Source files
------------

// File: rtl/alu_result_collector.sv
// -----------------------------------------------------------------------------
// alu_result_collector
//
// Sits behind ALU_TOP. Each cycle it looks at the four unit-valid flags, picks
// the result of the single unit that fired, normalises it to one DATA_WIDTH
// word tagged with the function code (ALU_FUN delayed by one cycle) and the
// carry, and buffers it in a first-word-fall-through FIFO drained through a
// valid/ready handshake. Sticky statistics count malformed (multi-flag)
// cycles and results dropped because the FIFO was full.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   ALU_FUN           function code driven into ALU_TOP this cycle
//   Arith_OUT         arithmetic result,  Carry_Out its carry
//   logic_OUT         16-bit logic result
//   CMP_OUT           4-bit compare result
//   SHIFT_OUT         17-bit shift result
//   Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag   unit-valid flags
//   Res_Ready         consumer accepts the head entry
//   CLR_Stats         clears Err_Multi, Drop_Cnt, Err_Cnt
//   Res_Valid         head entry valid
//   Res_Data, Res_Fun, Res_Carry   head entry fields
//   Fill_Level, Full  occupancy
//   Err_Multi         sticky: a multi-flag cycle was seen
//   Drop_Cnt, Err_Cnt saturating drop / multi-flag counters
// -----------------------------------------------------------------------------
module alu_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [3:0]               ALU_FUN,
  input  logic [31:0]              Arith_OUT,
  input  logic                     Carry_Out,
  input  logic                     Arith_Flag,
  input  logic                     Logic_Flag,
  input  logic                     CMP_Flag,
  input  logic                     Shift_Flag,
  input  logic [15:0]              logic_OUT,
  input  logic [3:0]               CMP_OUT,
  input  logic [16:0]              SHIFT_OUT,
  input  logic                     Res_Ready,
  input  logic                     CLR_Stats,
  output logic                     Res_Valid,
  output logic [DATA_WIDTH-1:0]    Res_Data,
  output logic [3:0]               Res_Fun,
  output logic                     Res_Carry,
  output logic [$clog2(DEPTH):0]   Fill_Level,
  output logic                     Full,
  output logic                     Err_Multi,
  output logic [CNT_WIDTH-1:0]     Drop_Cnt,
  output logic [CNT_WIDTH-1:0]     Err_Cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [3:0]             r_fun_d;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [FILL_W-1:0]      r_fill;
  logic                   r_err_multi;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;
  logic [CNT_WIDTH-1:0]   r_err_cnt;

  logic [DATA_WIDTH-1:0]  r_mem_data  [DEPTH];
  logic [3:0]             r_mem_fun   [DEPTH];
  logic                   r_mem_carry [DEPTH];

  logic [2:0]             w_nflags;
  logic                   w_one;
  logic                   w_multi;
  logic [DATA_WIDTH-1:0]  w_cand_data;
  logic                   w_cand_carry;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  // Flag decode: exactly one flag selects a result, more than one is an error.
  assign w_nflags = 3'(Arith_Flag) + 3'(Logic_Flag) + 3'(CMP_Flag) + 3'(Shift_Flag);
  assign w_one    = (w_nflags == 3'd1);
  assign w_multi  = (w_nflags > 3'd1);

  always_comb begin
    w_cand_data  = '0;
    w_cand_carry = 1'b0;
    if (Arith_Flag) begin
      w_cand_data  = DATA_WIDTH'(Arith_OUT);
      w_cand_carry = Carry_Out;
    end else if (Logic_Flag) begin
      w_cand_data  = DATA_WIDTH'(logic_OUT);
    end else if (CMP_Flag) begin
      w_cand_data  = DATA_WIDTH'(CMP_OUT);
    end else if (Shift_Flag) begin
      w_cand_data  = DATA_WIDTH'(SHIFT_OUT);
    end
  end

  assign w_full  = (r_fill == FILL_W'(DEPTH));
  assign w_empty = (r_fill == '0);
  assign w_pop   = !w_empty && Res_Ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_one && (!w_full || w_pop);
  assign w_drop  = w_one && !w_push;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fun_d  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_fun[i]   <= '0;
        r_mem_carry[i] <= 1'b0;
      end
    end else begin
      r_fun_d <= ALU_FUN;
      if (w_push) begin
        r_mem_data[r_wr_ptr]  <= w_cand_data;
        r_mem_fun[r_wr_ptr]   <= r_fun_d;
        r_mem_carry[r_wr_ptr] <= w_cand_carry;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_fill <= r_fill + 1'b1;
      end else if (w_pop && !w_push) begin
        r_fill <= r_fill - 1'b1;
      end
    end
  end

  // Statistics; a clear request wins over a coincident event
  always_ff @(posedge CLK) begin
    if (RST || CLR_Stats) begin
      r_err_multi <= 1'b0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_multi) begin
        r_err_multi <= 1'b1;
        r_err_cnt   <= sat_inc(r_err_cnt);
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end
  end

  assign Res_Valid  = !w_empty;
  assign Res_Data   = r_mem_data[r_rd_ptr];
  assign Res_Fun    = r_mem_fun[r_rd_ptr];
  assign Res_Carry  = r_mem_carry[r_rd_ptr];
  assign Fill_Level = r_fill;
  assign Full       = w_full;
  assign Err_Multi  = r_err_multi;
  assign Drop_Cnt   = r_drop_cnt;
  assign Err_Cnt    = r_err_cnt;

endmodule

// File: tb/tb_alu_result_collector.sv
module tb_alu_result_collector;

  localparam int DEPTH = 4;
  localparam int CNT_MAX = 255;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  ALU_FUN = '0;
  logic [31:0] Arith_OUT = '0;
  logic        Carry_Out = 1'b0;
  logic        Arith_Flag = 1'b0, Logic_Flag = 1'b0, CMP_Flag = 1'b0, Shift_Flag = 1'b0;
  logic [15:0] logic_OUT = '0;
  logic [3:0]  CMP_OUT = '0;
  logic [16:0] SHIFT_OUT = '0;
  logic        Res_Ready = 1'b0;
  logic        CLR_Stats = 1'b0;
  logic        Res_Valid;
  logic [31:0] Res_Data;
  logic [3:0]  Res_Fun;
  logic        Res_Carry;
  logic [2:0]  Fill_Level;
  logic        Full;
  logic        Err_Multi;
  logic [7:0]  Drop_Cnt;
  logic [7:0]  Err_Cnt;

  alu_result_collector #(.DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .ALU_FUN(ALU_FUN), .Arith_OUT(Arith_OUT), .Carry_Out(Carry_Out),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
    .logic_OUT(logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT), .Res_Ready(Res_Ready),
    .CLR_Stats(CLR_Stats), .Res_Valid(Res_Valid), .Res_Data(Res_Data), .Res_Fun(Res_Fun),
    .Res_Carry(Res_Carry), .Fill_Level(Fill_Level), .Full(Full), .Err_Multi(Err_Multi),
    .Drop_Cnt(Drop_Cnt), .Err_Cnt(Err_Cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of tagged results plus plain integer statistics.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    logic        c;
  } entry_t;

  entry_t      m_q[$];
  logic [3:0]  m_prev_fun = '0;
  bit          m_err_multi = 0;
  int          m_drop = 0;
  int          m_err = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic model_step();
    int     nf;
    bit     pop;
    bit     accept;
    entry_t e;
    nf  = int'(Arith_Flag) + int'(Logic_Flag) + int'(CMP_Flag) + int'(Shift_Flag);
    pop = (m_q.size() > 0) && Res_Ready;
    if (RST) begin
      m_q.delete();
      m_prev_fun  = '0;
      m_err_multi = 0;
      m_drop      = 0;
      m_err       = 0;
      return;
    end
    accept = 0;
    if (nf == 1) begin
      e.f = m_prev_fun;
      e.c = 1'b0;
      if (Arith_Flag)      begin e.d = Arith_OUT; e.c = Carry_Out; end
      else if (Logic_Flag) e.d = {16'h0, logic_OUT};
      else if (CMP_Flag)   e.d = {28'h0, CMP_OUT};
      else                 e.d = {15'h0, SHIFT_OUT};
      accept = (m_q.size() < DEPTH) || pop;
    end
    if (pop) void'(m_q.pop_front());
    if (accept) m_q.push_back(e);
    if (CLR_Stats) begin
      m_err_multi = 0;
      m_drop      = 0;
      m_err       = 0;
    end else begin
      if (nf > 1) begin
        m_err_multi = 1;
        m_err = min_sat(m_err + 1);
      end
      if (nf == 1 && !accept) m_drop = min_sat(m_drop + 1);
    end
    m_prev_fun = ALU_FUN;
  endtask

  task automatic check_all();
    check_eq("valid", 32'(Res_Valid), 32'(m_q.size() > 0));
    check_eq("fill", 32'(Fill_Level), 32'(m_q.size()));
    check_eq("full", 32'(Full), 32'(m_q.size() == DEPTH));
    check_eq("err_multi", 32'(Err_Multi), 32'(m_err_multi));
    check_eq("drop_cnt", 32'(Drop_Cnt), 32'(m_drop));
    check_eq("err_cnt", 32'(Err_Cnt), 32'(m_err));
    if (m_q.size() > 0) begin
      check_eq("head_data", Res_Data, m_q[0].d);
      check_eq("head_fun", 32'(Res_Fun), 32'(m_q[0].f));
      check_eq("head_carry", 32'(Res_Carry), 32'(m_q[0].c));
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  task automatic idle();
    Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
    CLR_Stats = 0; RST = 0;
  endtask

  task automatic push_logic(input logic [15:0] v, input logic [3:0] fun);
    idle();
    Logic_Flag = 1; logic_OUT = v; ALU_FUN = fun;
  endtask

  initial begin
    // Reset
    RST = 1;
    cyc(); cyc();
    check_eq("rst_valid", 32'(Res_Valid), 32'd0);
    check_eq("rst_fill", 32'(Fill_Level), 32'd0);
    check_eq("rst_drop", 32'(Drop_Cnt), 32'd0);
    check_eq("rst_errm", 32'(Err_Multi), 32'd0);
    check_eq("rst_data", Res_Data, 32'd0);
    check_eq("rst_fun", 32'(Res_Fun), 32'd0);
    check_eq("rst_carry", 32'(Res_Carry), 32'd0);

    // Arithmetic push with carry
    idle(); ALU_FUN = 4'd0;
    cyc();
    Arith_Flag = 1; Arith_OUT = 32'hFFFF_FFF6; Carry_Out = 1; ALU_FUN = 4'd5;
    cyc();
    check_eq("arith_valid", 32'(Res_Valid), 32'd1);
    check_eq("arith_data", Res_Data, 32'hFFFF_FFF6);
    check_eq("arith_fun", 32'(Res_Fun), 32'd0);
    check_eq("arith_carry", 32'(Res_Carry), 32'd1);
    check_eq("arith_fill1", 32'(Fill_Level), 32'd1);
    idle(); Carry_Out = 0; Res_Ready = 1;
    cyc();
    check_eq("arith_fill0", 32'(Fill_Level), 32'd0);

    // Normalisation of logic / compare / shift results
    idle(); Res_Ready = 0; ALU_FUN = 4'd7;
    cyc();
    push_logic(16'hFFF0, 4'd11);
    cyc();
    idle(); CMP_Flag = 1; CMP_OUT = 4'd3; ALU_FUN = 4'd13;
    cyc();
    idle(); Shift_Flag = 1; SHIFT_OUT = 17'h10014; ALU_FUN = 4'd0;
    cyc();
    idle();
    cyc();
    check_eq("norm_d0", Res_Data, 32'h0000_FFF0);
    check_eq("norm_f0", 32'(Res_Fun), 32'd7);
    Res_Ready = 1;
    cyc();
    check_eq("norm_d1", Res_Data, 32'h0000_0003);
    check_eq("norm_f1", 32'(Res_Fun), 32'd11);
    cyc();
    check_eq("norm_d2", Res_Data, 32'h0001_0014);
    check_eq("norm_f2", 32'(Res_Fun), 32'd13);
    check_eq("norm_c2", 32'(Res_Carry), 32'd0);
    cyc();
    check_eq("norm_empty", 32'(Res_Valid), 32'd0);

    // Full FIFO and drops, then simultaneous push and pop across the wrap
    Res_Ready = 0;
    for (int i = 0; i < 6; i++) begin
      push_logic(16'h0100 + 16'(i), 4'(i));
      cyc();
    end
    check_eq("full_fill", 32'(Fill_Level), 32'd4);
    check_eq("full_flag", 32'(Full), 32'd1);
    check_eq("full_drop", 32'(Drop_Cnt), 32'd2);
    push_logic(16'h0200, 4'd9); Res_Ready = 1;
    cyc();
    check_eq("pp_fill", 32'(Fill_Level), 32'd4);
    check_eq("pp_drop", 32'(Drop_Cnt), 32'd2);
    check_eq("pp_head", Res_Data, 32'h0000_0101);
    idle();
    for (int i = 0; i < 5; i++) cyc();
    check_eq("drain_empty", 32'(Fill_Level), 32'd0);

    // Multi-flag error, clear, then drop-counter saturation
    idle(); Res_Ready = 0; Arith_Flag = 1; Logic_Flag = 1;
    cyc();
    check_eq("multi_fill", 32'(Fill_Level), 32'd0);
    check_eq("multi_errm", 32'(Err_Multi), 32'd1);
    check_eq("multi_errc", 32'(Err_Cnt), 32'd1);
    idle(); CLR_Stats = 1;
    cyc();
    check_eq("clr_errm", 32'(Err_Multi), 32'd0);
    check_eq("clr_errc", 32'(Err_Cnt), 32'd0);
    check_eq("clr_drop", 32'(Drop_Cnt), 32'd0);
    for (int i = 0; i < 304; i++) begin
      push_logic(16'(i), 4'(i));
      cyc();
    end
    check_eq("sat_drop", 32'(Drop_Cnt), 32'd255);

    // Reset in the middle of traffic with a coinciding push
    idle(); CLR_Stats = 1; Res_Ready = 1;
    cyc();
    idle();
    for (int i = 0; i < 5; i++) cyc();
    Res_Ready = 0;
    for (int i = 0; i < 3; i++) begin
      push_logic(16'h0300 + 16'(i), 4'(i));
      cyc();
    end
    check_eq("mid_fill3", 32'(Fill_Level), 32'd3);
    push_logic(16'h0333, 4'd3); RST = 1;
    cyc();
    check_eq("mid_fill0", 32'(Fill_Level), 32'd0);
    check_eq("mid_valid", 32'(Res_Valid), 32'd0);
    check_eq("mid_data", Res_Data, 32'd0);
    idle();
    cyc();
    check_eq("mid_after", 32'(Fill_Level), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      idle();
      ALU_FUN   = 4'($urandom);
      Arith_OUT = $urandom;
      Carry_Out = 1'($urandom);
      logic_OUT = 16'($urandom);
      CMP_OUT   = 4'($urandom);
      SHIFT_OUT = 17'($urandom);
      r = $urandom_range(0, 9);
      if (r >= 2 && r <= 7) begin
        case ($urandom_range(0, 3))
          0: Arith_Flag = 1;
          1: Logic_Flag = 1;
          2: CMP_Flag = 1;
          default: Shift_Flag = 1;
        endcase
      end else if (r >= 8) begin
        {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag} = 4'($urandom);
      end
      Res_Ready = ($urandom_range(0, 2) != 0);
      CLR_Stats = ($urandom_range(0, 63) == 0);
      RST       = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
